bit_serial_multiplier: RTL and testbench
========================================

Name: bit_serial_multiplier

Overview:
- LSB-first serial-serial two's-complement multiplier.
- Operands x and y arrive one bit per clock. One product bit leaves per clock on p, modulo 2^K.
- first_bit and last_bit frame each word.
- Used as a serial arithmetic primitive in bit-serial datapaths. K = 2N+1 holds the exact product of two N-bit signed operands.

Parameters:
- K, default 7: serial word length in bits. Operand/product width; the product is computed modulo 2^K. Must be >= 2.

Ports:
- clk  input  1  rising-edge clock.
- aresetn  input  1  synchronous, active-low reset (sampled on clk).
- x  input  1  multiplicand bit, LSB first, sign-extended by the source to K bits.
- y  input  1  multiplier bit, LSB first, sign-extended by the source to K bits.
- first_bit  input  1  high in the cycle carrying bit 0 of x/y; starts a new word.
- last_bit  input  1  high = idle / word ended; low = word in progress.
- p  output  1  registered product bit, LSB first.

Behaviour:
- Internal state:
  - X and Y registers, K bits each, holding the operand bits received so far.
  - Accumulator A, K+1 bits, in a shifted frame (current bit weight = LSB).
  - One-hot position register pos, K bits.
  - Output register p.
- Reset (aresetn=0 at a clk edge): X, Y, A, pos and p all cleared to 0. Reset mid-word abandons the word. p stays 0 until the next first_bit.
- Start edge (first_bit=1, sampled on clk):
  - Clear X, Y, A.
  - Set X[0]=x, Y[0]=y.
  - p <= x&y; A <= (x&y)>>1.
  - pos <= 2 (one-hot bit 1).
- Run edge, bit i>0 (first_bit=0, last_bit=0, pos nonzero):
  - S = A + (x ? (Y | y<<i) : 0) + (y ? X : 0), using X and Y from before this edge.
  - p <= S[0]; A <= S>>1.
  - X[i] <= x; Y[i] <= y; pos <= pos<<1.
- Latency: product bit i is on p immediately after the clk edge that samples x[i]/y[i]. It is valid for one cycle.
- Word length: after K bits, pos becomes 0. Further run edges shift in nothing new (terms masked), so p emits the continuing shifted accumulator. Only bits 0..K-1 are defined product bits.
- Idle (last_bit=1, first_bit=0): state is held and p is driven to 0.
- first_bit and last_bit both high: first_bit has priority and the start edge executes.
- first_bit asserted mid-word: the current word is abandoned and a new word starts.
- Result width: product bits 0..K-1 equal (x*y) mod 2^K. This is exact signed for |x|,|y| < 2^((K-1)/2).

Decomposition:
- Shared package:
  - Default K (=7).
  - A function giving the accumulator width K+1.
  - A helper function computing the expected modulo-2^K product, for the bench scoreboard.
- Single flat module. No sub-module is needed; the adder is one behavioural K+1-bit add.

Test Plan (all with K=7):
- Reset, then idle with last_bit=1 -> p=0 throughout; after aresetn deasserts, p=0 until first_bit.
- x=3, y=3, bits 0..5 LSB first, first_bit on bit 0 -> p bits collected after each edge = 9 (0b001001).
- x=5, y=5 -> 25 (0b011001).
- x=5, y=7 back-to-back after a one-cycle idle gap -> 35 (0b100011). No residue from the previous word.
- Signed: x=-3 (0b1111101), y=2 (0b0000010), 7 bits -> p = 0b1111010 (-6 mod 128 = 122).
- Abort: drop aresetn at bit 3 of a 5*7 word, release it, then run 3*3 -> p=0 during and after reset, and the next word gives 9.
- Exhaustive: all signed 3-bit pairs a,b in [-4..3] -> 7-bit result equals a*b mod 128.

Source files
------------

// File: rtl/bit_serial_multiplier_pkg.sv
// Shared definitions for the LSB-first serial-serial two's-complement multiplier.
//   K_DEFAULT  : default serial word length (2N+1 holds an exact N x N signed product)
//   edge_e     : what a clock edge does, derived from first_bit/last_bit
//   acc_width  : accumulator width for a given word length
//   prod_mod   : reference product modulo 2^k, intended for checking only
package bit_serial_multiplier_pkg;

  localparam int unsigned K_DEFAULT = 7;

  typedef enum logic [1:0] {
    EDGE_IDLE  = 2'd0,
    EDGE_START = 2'd1,
    EDGE_RUN   = 2'd2
  } edge_e;

  function automatic int unsigned acc_width(input int unsigned k);
    return k + 1;
  endfunction

  function automatic logic [63:0] prod_mod(input longint a, input longint b,
                                           input int unsigned k);
    longint r;
    r = a * b;
    return 64'(r) & ((64'd1 << k) - 64'd1);
  endfunction

endpackage

// File: rtl/bit_serial_multiplier.sv
// LSB-first serial-serial two's-complement multiplier.
// One bit of x and y enters per clock; one product bit leaves per clock on p.
// Product bits 0..K-1 equal (x*y) mod 2^K.
// Ports:
//   clk        rising-edge clock
//   aresetn    synchronous active-low reset
//   x, y       operand bits, LSB first, sign-extended to K bits by the source
//   first_bit  marks bit 0 of a word (starts a new word, overrides last_bit)
//   last_bit   high = idle (state held, p forced 0); low = word in progress
//   p          registered product bit
module bit_serial_multiplier
  import bit_serial_multiplier_pkg::*;
#(
  parameter int unsigned K = K_DEFAULT
) (
  input  logic clk,
  input  logic aresetn,
  input  logic x,
  input  logic y,
  input  logic first_bit,
  input  logic last_bit,
  output logic p
);

  localparam int unsigned AW = acc_width(K);

  logic [K-1:0]  x_q, x_d;
  logic [K-1:0]  y_q, y_d;
  logic [AW-1:0] a_q, a_d;
  logic [K-1:0]  pos_q, pos_d;
  logic          p_q, p_d;

  edge_e         edge_kind;
  logic          run;
  logic [K-1:0]  term_x;
  logic [K-1:0]  term_y;
  logic [AW-1:0] sum;

  always_comb begin
    if (first_bit)      edge_kind = EDGE_START;
    else if (!last_bit) edge_kind = EDGE_RUN;
    else                edge_kind = EDGE_IDLE;
  end

  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    a_d    = a_q;
    pos_d  = pos_q;
    p_d    = 1'b0;
    run    = |pos_q;
    term_x = '0;
    term_y = '0;
    sum    = '0;

    unique case (edge_kind)
      EDGE_START: begin
        x_d      = '0;
        x_d[0]   = x;
        y_d      = '0;
        y_d[0]   = y;
        p_d      = x & y;
        // (x&y)>>1 is always zero
        a_d      = '0;
        pos_d    = '0;
        pos_d[1] = 1'b1;
      end
      EDGE_RUN: begin
        // Frame shifts by one each edge, so bit j of the sum carries weight 2^(i+j).
        // x_i pairs with earlier y bits plus y_i itself (at pos), y_i with earlier x bits.
        // Once pos has run off the top both terms vanish and A just drains out.
        term_x = (x && run) ? (y_q | (y ? pos_q : '0)) : '0;
        term_y = (y && run) ? x_q : '0;
        sum    = a_q + AW'(term_x) + AW'(term_y);
        p_d    = sum[0];
        a_d    = sum >> 1;
        x_d    = x_q | (x ? pos_q : '0);
        y_d    = y_q | (y ? pos_q : '0);
        pos_d  = pos_q << 1;
      end
      default: begin
        p_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      x_q   <= '0;
      y_q   <= '0;
      a_q   <= '0;
      pos_q <= '0;
      p_q   <= 1'b0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      a_q   <= a_d;
      pos_q <= pos_d;
      p_q   <= p_d;
    end
  end

  assign p = p_q;

endmodule

// File: tb/tb_bit_serial_multiplier.sv
module tb_bit_serial_multiplier;
  import bit_serial_multiplier_pkg::*;

  localparam int unsigned K = 7;

  logic clk;
  logic aresetn;
  logic x;
  logic y;
  logic first_bit;
  logic last_bit;
  logic p;

  bit_serial_multiplier #(.K(K)) dut (
    .clk       (clk),
    .aresetn   (aresetn),
    .x         (x),
    .y         (y),
    .first_bit (first_bit),
    .last_bit  (last_bit),
    .p         (p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         chk;
    logic         exp_bit;
    logic         in_word;
    int           bidx;
    logic         lit_chk;
    logic [K-1:0] lit;
    string        name;
  } exp_t;

  exp_t q[$];

  int checks = 0;
  int errors = 0;

  // Compare process: one expectation per clock edge, checked 1 time unit after it.
  exp_t         e;
  logic [K-1:0] acc;
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      if (e.chk) begin
        checks++;
        if (p !== e.exp_bit) begin
          errors++;
          $display("FAIL %s: p=%b expected %b at %0t", e.name, p, e.exp_bit, $time);
        end
      end
      if (e.in_word) begin
        if (e.bidx == 0) acc = '0;
        acc[e.bidx] = p;
        if (e.lit_chk && e.bidx == int'(K) - 1) begin
          checks++;
          if (acc !== e.lit) begin
            errors++;
            $display("FAIL %s word: got %b expected %b", e.name, acc, e.lit);
          end
        end
      end
    end
  end

  // Drive one clock worth of inputs and queue the expectation for the next edge.
  task automatic cycle(input logic rn, input logic fb, input logic lb,
                       input logic xb, input logic yb,
                       input logic chk, input logic expb,
                       input logic inw, input int bidx,
                       input logic litc, input logic [K-1:0] lit,
                       input string name);
    exp_t n;
    aresetn   = rn;
    first_bit = fb;
    last_bit  = lb;
    x         = xb;
    y         = yb;
    n.chk = chk; n.exp_bit = expb; n.in_word = inw; n.bidx = bidx;
    n.lit_chk = litc; n.lit = lit; n.name = name;
    q.push_back(n);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input string name);
    cycle(1'b1, 1'b0, 1'b1, 1'($urandom), 1'($urandom), 1'b1, 1'b0,
          1'b0, 0, 1'b0, '0, name);
  endtask

  // Full K-bit word; expected bits come from the arithmetic product mod 2^K.
  // nbits < K abandons the word early (unchecked literal).
  task automatic word(input longint a, input longint b, input int nbits,
                      input logic litc, input logic [K-1:0] lit,
                      input logic both_on_start, input string name);
    logic [K-1:0] av, bv, pv;
    av = K'(a);
    bv = K'(b);
    pv = K'(prod_mod(a, b, K));
    for (int i = 0; i < nbits; i++) begin
      cycle(1'b1, i == 0, (i == 0) ? both_on_start : 1'b0, av[i], bv[i],
            1'b1, pv[i], 1'b1, i, litc && nbits == int'(K), lit, name);
    end
  endtask

  initial begin
    aresetn = 1'b0; first_bit = 1'b0; last_bit = 1'b1; x = 1'b0; y = 1'b0;

    // Reset while idle, then idle, then run edges with no word started.
    for (int i = 0; i < 3; i++)
      cycle(1'b0, 1'b0, 1'b1, 1'($urandom), 1'($urandom), 1'b1, 1'b0,
            1'b0, 0, 1'b0, '0, "reset");
    for (int i = 0; i < 3; i++) idle("idle_after_reset");
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 1'b0, 1'b0, 1'($urandom), 1'($urandom), 1'b1, 1'b0,
            1'b0, 0, 1'b0, '0, "run_without_start");

    // Directed words pinned to hand-computed results.
    word(3, 3, K, 1'b1, 7'b0001001, 1'b0, "3x3");
    idle("gap");
    word(5, 5, K, 1'b1, 7'b0011001, 1'b0, "5x5");
    idle("gap");
    word(5, 7, K, 1'b1, 7'b0100011, 1'b0, "5x7");
    idle("gap");
    word(-3, 2, K, 1'b1, 7'b1111010, 1'b0, "m3x2");
    idle("gap");
    // Back-to-back words with first_bit and last_bit both high on bit 0.
    word(-4, 3, K, 1'b1, 7'b1110100, 1'b1, "m4x3_both");
    word(2, -1, K, 1'b1, 7'b1111110, 1'b0, "2xm1_b2b");
    idle("gap");

    // Abort by reset at bit 3 of 5x7, then 3x3.
    word(5, 7, 3, 1'b0, '0, 1'b0, "abort_5x7");
    for (int i = 0; i < 2; i++)
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0,
            1'b0, 0, 1'b0, '0, "abort_reset");
    for (int i = 0; i < 2; i++)
      cycle(1'b1, 1'b0, 1'b0, 1'($urandom), 1'($urandom), 1'b1, 1'b0,
            1'b0, 0, 1'b0, '0, "after_abort");
    word(3, 3, K, 1'b1, 7'b0001001, 1'b0, "3x3_after_abort");
    idle("gap");

    // Abandon mid-word with a new first_bit.
    word(3, -2, 4, 1'b0, '0, 1'b0, "abandoned");
    word(-3, -3, K, 1'b1, 7'b0001001, 1'b0, "m3xm3_restart");
    idle("gap");

    // Exhaustive signed 3-bit operands.
    for (int a = -4; a <= 3; a++)
      for (int b = -4; b <= 3; b++) begin
        word(longint'(a), longint'(b), K, 1'b0, '0, 1'($urandom), "exh3");
        if ($urandom_range(0, 1) == 1) idle("exh_gap");
      end

    // Randomized full-range K-bit operands with random gaps and restarts.
    for (int n = 0; n < 150; n++) begin
      longint a, b;
      a = longint'($urandom_range(0, (1 << K) - 1)) - (longint'(1) << (K - 1));
      b = longint'($urandom_range(0, (1 << K) - 1)) - (longint'(1) << (K - 1));
      if ($urandom_range(0, 7) == 0)
        word(a, b, int'($urandom_range(1, K - 1)), 1'b0, '0, 1'b0, "rand_abandon");
      else
        word(a, b, K, 1'b0, '0, 1'($urandom), "rand");
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) idle("rand_gap");
    end

    idle("final");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
